// File: rtl/local_flit_depacketizer.sv
// Router local-port consumer: packs 4-bit flits into 32-bit spike words
// and queues them for the neuron core behind a valid/ready handshake.
module local_flit_depacketizer #(
  parameter int FLIT_W = 4,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FLIT_W-1:0]        flit_in,
  input  logic                     flit_wr,
  output logic                     local_neuron_full,
  output logic [WORD_W-1:0]        spike_data,
  output logic                     spike_valid,
  input  logic                     spike_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     partial,
  output logic                     overflow
);

  localparam int FLITS = WORD_W / FLIT_W;
  localparam int CW = $clog2(FLITS);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FLITS - 1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_HI = LW'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    ASSEMBLE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [LW-1:0]     level_nxt;
  logic [WORD_W-1:0] word;
  logic              last_flit;
  logic              pop;
  logic              push_ok;

  assign last_flit = flit_wr && (cnt == CNT_LAST);
  assign word = {shift_reg[WORD_W-FLIT_W-1:0], flit_in};
  assign pop = spike_valid && spike_ready;
  // A full FIFO still takes the new word if the head leaves this edge
  assign push_ok = last_flit && ((level != LVL_MAX) || pop);

  assign spike_valid = (level != '0);
  assign spike_data = mem[rd_ptr];
  assign fifo_level = level;
  assign partial = (state == ASSEMBLE);

  always_comb begin
    level_nxt = level;
    unique case ({push_ok, pop})
      2'b10: level_nxt = level + LW'(1);
      2'b01: level_nxt = level - LW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      shift_reg <= '0;
    end else if (flit_wr) begin
      shift_reg <= word;
      unique case (state)
        IDLE: begin
          state <= ASSEMBLE;
          cnt <= cnt + CW'(1);
        end
        ASSEMBLE: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      local_neuron_full <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= word;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (last_flit && !push_ok) overflow <= 1'b1;
      level <= level_nxt;
      // One level of headroom hides the lag of this registered flag
      local_neuron_full <= (level_nxt >= LVL_HI);
    end
  end

endmodule

// File: tb/tb_local_flit_depacketizer.sv
// Directed bench for local_flit_depacketizer: vector table for
// assembly timing, hand sequences for FIFO full/drop and reset.
module tb_local_flit_depacketizer;

  logic        clk;
  logic        reset;
  logic [3:0]  flit_in;
  logic        flit_wr;
  logic        local_neuron_full;
  logic [31:0] spike_data;
  logic        spike_valid;
  logic        spike_ready;
  logic [2:0]  fifo_level;
  logic        partial;
  logic        overflow;

  int total = 0;
  int bad = 0;

  local_flit_depacketizer dut (
    .clk(clk),
    .reset(reset),
    .flit_in(flit_in),
    .flit_wr(flit_wr),
    .local_neuron_full(local_neuron_full),
    .spike_data(spike_data),
    .spike_valid(spike_valid),
    .spike_ready(spike_ready),
    .fifo_level(fifo_level),
    .partial(partial),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  flit;
    logic        wr;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  el;
    logic        ep;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int n,
                           input logic rdy_last);
    for (int i = 0; i < n; i++) begin
      flit_in = w[31-4*i -: 4];
      flit_wr = 1'b1;
      spike_ready = (i == 7) ? rdy_last : 1'b0;
      tick();
    end
    flit_wr = 1'b0;
    spike_ready = 1'b0;
  endtask

  task automatic drain(input logic [31:0] w);
    chk("drain_valid", 32'(spike_valid), 32'd1);
    chk("drain_data", spike_data, w);
    spike_ready = 1'b1;
    tick();
    spike_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic lvl_chk(input string nm, input logic [2:0] l,
                         input logic f, input logic o);
    chk({nm, "_level"}, 32'(fifo_level), 32'(l));
    chk({nm, "_full"}, 32'(local_neuron_full), 32'(f));
    chk({nm, "_ovf"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    flit_in = '0;
    flit_wr = 1'b0;
    spike_ready = 1'b0;

    // Reset with random inputs, then release with no traffic
    for (int i = 0; i < 4; i++) begin
      flit_in = 4'($urandom);
      flit_wr = 1'($urandom);
      spike_ready = 1'($urandom);
      tick();
      chk("rst_outs", {spike_data}, 32'h0);
      chk("rst_flags", {27'd0, spike_valid, fifo_level, partial},
          32'h0);
      chk("rst_bp", {30'd0, overflow, local_neuron_full}, 32'h0);
    end
    flit_wr = 1'b0;
    spike_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("rel_outs", spike_data, 32'h0);
    chk("rel_flags", {27'd0, spike_valid, fifo_level, partial}, 32'h0);
    chk("rel_bp", {30'd0, overflow, local_neuron_full}, 32'h0);

    // Back-to-back DEADBEEF, then the same word with gaps
    tbl.push_back('{4'hD, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hE, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hA, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hD, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hB, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hE, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hE, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hF, 1, 1, 1, 32'hDEADBEEF, 3'd1, 0});
    tbl.push_back('{4'h0, 0, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{4'hD, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'h7, 0, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hE, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hA, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'h3, 0, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'h5, 0, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hD, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hB, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'h1, 0, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'h9, 0, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hC, 0, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hE, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hE, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{4'hF, 1, 1, 1, 32'hDEADBEEF, 3'd1, 0});
    tbl.push_back('{4'h0, 0, 1, 0, 32'h0, 3'd0, 0});

    foreach (tbl[i]) begin
      flit_in = tbl[i].flit;
      flit_wr = tbl[i].wr;
      spike_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(spike_valid),
          32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), spike_data,
                         tbl[i].ed);
      chk($sformatf("vec%0d_level", i), 32'(fifo_level),
          32'(tbl[i].el));
      chk($sformatf("vec%0d_partial", i), 32'(partial),
          32'(tbl[i].ep));
      chk($sformatf("vec%0d_full", i), 32'(local_neuron_full), 32'd0);
    end
    flit_wr = 1'b0;
    spike_ready = 1'b0;

    // Fill, force past full, drop one, drain in order
    send_word(32'hA1B2C3D4, 8, 1'b0);
    lvl_chk("fill1", 3'd1, 1'b0, 1'b0);
    send_word(32'h55667788, 8, 1'b0);
    lvl_chk("fill2", 3'd2, 1'b0, 1'b0);
    send_word(32'h9ABCDEF0, 8, 1'b0);
    lvl_chk("fill3", 3'd3, 1'b1, 1'b0);
    send_word(32'h0F1E2D3C, 8, 1'b0);
    lvl_chk("fill4", 3'd4, 1'b1, 1'b0);
    send_word(32'h13579BDF, 8, 1'b0);
    lvl_chk("drop", 3'd4, 1'b1, 1'b1);
    drain(32'hA1B2C3D4);
    drain(32'h55667788);
    drain(32'h9ABCDEF0);
    drain(32'h0F1E2D3C);
    lvl_chk("drained", 3'd0, 1'b0, 1'b1);
    chk("drained_valid", 32'(spike_valid), 32'd0);

    // Full FIFO with a simultaneous pop and push
    do_reset();
    lvl_chk("rst2", 3'd0, 1'b0, 1'b0);
    send_word(32'h11112222, 8, 1'b0);
    send_word(32'h33334444, 8, 1'b0);
    send_word(32'h55556666, 8, 1'b0);
    send_word(32'h77778888, 8, 1'b0);
    lvl_chk("full", 3'd4, 1'b1, 1'b0);
    send_word(32'h9999AAAA, 8, 1'b1);
    lvl_chk("pushpop", 3'd4, 1'b1, 1'b0);
    drain(32'h33334444);
    drain(32'h55556666);
    drain(32'h77778888);
    drain(32'h9999AAAA);
    lvl_chk("pp_drained", 3'd0, 1'b0, 1'b0);

    // Reset mid-packet discards the partial word
    send_word(32'h12345678, 5, 1'b0);
    chk("mid_partial", 32'(partial), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_partial", 32'(partial), 32'd0);
    chk("async_level", 32'(fifo_level), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    send_word(32'hCAFEF00D, 8, 1'b0);
    chk("cafe_level", 32'(fifo_level), 32'd1);
    drain(32'hCAFEF00D);
    chk("cafe_empty", 32'(spike_valid), 32'd0);
    chk("cafe_level0", 32'(fifo_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
